gb_port_arb: RTL

Two-requester arbiter and sequencer for the global-buffer (GB) single access port. It shares the port between the SoC host path (soc2gb) and the DDR2GB DMA engine. Each grant holds for a whole burst, and round-robin alternates ownership between bursts. The block registers the command into the GB banks and routes fixed-latency read data back to the requester that issued each read. It sits between the bus-interface/DMA logic and the GB bank array.

---
 rtl/gb_port_arb.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/gb_port_arb.sv
// gb_port_arb: round-robin burst arbiter and command register for the GB single access port.
// Optional macro GB_ARB_STARVE_GUARD_EN caps a grant at MAX_BEATS accepted beats.
module gb_port_arb #(
   parameter int RD_LAT    = 2,
   parameter int MAX_BEATS = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         h_req,
   output logic         h_ready,
   input  logic         h_last,
   input  logic         h_wen,
   input  logic         h_ab_sel,
   input  logic [12:0]  h_addr,
   input  logic [15:0]  h_ram_sel,
   input  logic [255:0] h_wdata,
   output logic         h_rvalid,
   input  logic         d_req,
   output logic         d_ready,
   input  logic         d_last,
   input  logic         d_wen,
   input  logic         d_ab_sel,
   input  logic [12:0]  d_addr,
   input  logic [15:0]  d_ram_sel,
   input  logic [255:0] d_wdata,
   output logic         d_rvalid,
   output logic [255:0] rdata,
   output logic         gb_ab_sel,
   output logic [12:0]  gb_addr,
   output logic [15:0]  gb_ram_sel,
   output logic         gb_wen,
   output logic         gb_ren,
   output logic [255:0] gb_wdata,
   input  logic [255:0] gb_rdata,
   output logic [1:0]   owner
);

   if (RD_LAT < 1 || RD_LAT > 8 || MAX_BEATS < 1) begin : g_bad_cfg
      $error("gb_port_arb: RD_LAT must be 1..8 and MAX_BEATS at least 1");
   end

   typedef enum logic [1:0] {IDLE = 2'd0, G_HOST = 2'd1, G_DMA = 2'd2} state_t;

   state_t            r_state;
   logic              r_rr;      // 1 = DMA was served last
   logic [RD_LAT:0]   r_tag_v;
   logic [RD_LAT:0]   r_tag_d;

   logic              w_h_acc;
   logic              w_d_acc;
   logic              w_acc;
   logic              w_sel_d;
   logic              w_wen;
   logic              w_cap;

   assign h_ready = (r_state == G_HOST);
   assign d_ready = (r_state == G_DMA);
   assign owner   = 2'(r_state);
   assign w_sel_d = (r_state == G_DMA);
   assign w_h_acc = h_req & h_ready;
   assign w_d_acc = d_req & d_ready;
   assign w_acc   = w_h_acc | w_d_acc;
   assign w_wen   = w_sel_d ? d_wen : h_wen;

`ifdef GB_ARB_STARVE_GUARD_EN
   localparam int CNT_W = $clog2(MAX_BEATS + 1);
   logic [CNT_W-1:0] r_beats;

   // Cut the grant when the MAX_BEATS-th beat of this grant is being accepted.
   assign w_cap = (r_beats == CNT_W'(MAX_BEATS - 1));

   always_ff @(posedge clk) begin
      if (rst || r_state == IDLE) begin
         r_beats <= '0;
      end else if (w_acc) begin
         r_beats <= r_beats + 1'b1;
      end
   end
`else
   assign w_cap = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_rr    <= 1'b1;
      end else begin
         case (r_state)
            IDLE: begin
               if (h_req && (!d_req || r_rr)) begin
                  r_state <= G_HOST;
               end else if (d_req) begin
                  r_state <= G_DMA;
               end
            end
            G_HOST: begin
               if (w_h_acc && (h_last || w_cap)) begin
                  r_state <= IDLE;
                  r_rr    <= 1'b0;
               end
            end
            G_DMA: begin
               if (w_d_acc && (d_last || w_cap)) begin
                  r_state <= IDLE;
                  r_rr    <= 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Command stage: accepted beat lands on the GB port one cycle later.
   always_ff @(posedge clk) begin
      if (rst) begin
         gb_ab_sel  <= 1'b0;
         gb_addr    <= '0;
         gb_ram_sel <= '0;
         gb_wdata   <= '0;
         gb_wen     <= 1'b0;
         gb_ren     <= 1'b0;
      end else if (w_acc) begin
         gb_ab_sel  <= w_sel_d ? d_ab_sel  : h_ab_sel;
         gb_addr    <= w_sel_d ? d_addr    : h_addr;
         gb_ram_sel <= w_sel_d ? d_ram_sel : h_ram_sel;
         gb_wdata   <= w_sel_d ? d_wdata   : h_wdata;
         gb_wen     <= w_wen;
         gb_ren     <= ~w_wen;
      end else begin
         gb_wen     <= 1'b0;
         gb_ren     <= 1'b0;
      end
   end

   // Read tags travel independently of the grant, so ownership changes never disturb them.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_tag_v <= '0;
         r_tag_d <= '0;
      end else begin
         r_tag_v <= {r_tag_v[RD_LAT-1:0], w_acc & ~w_wen};
         r_tag_d <= {r_tag_d[RD_LAT-1:0], w_sel_d};
      end
   end

   assign h_rvalid = r_tag_v[RD_LAT] & ~r_tag_d[RD_LAT];
   assign d_rvalid = r_tag_v[RD_LAT] &  r_tag_d[RD_LAT];
   assign rdata    = r_tag_v[RD_LAT] ? gb_rdata : '0;

endmodule
